// File: rtl/riscv_supervisor_pkg.sv
// Shared types for the RI5CY run supervisor.
//   sup_state_e  : supervisor FSM state (exported on state_o, zero-extended to 3 bits)
//   sup_status_e : encoded final verdict (exported on status_o)
package riscv_supervisor_pkg;

  typedef enum logic [1:0] {
    WAIT_BIST  = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } sup_state_e;

  typedef enum logic [2:0] {
    ST_NONE     = 3'd0,
    ST_PASS     = 3'd1,
    ST_FAIL     = 3'd2,
    ST_EXIT_OK  = 3'd3,
    ST_EXIT_ERR = 3'd4,
    ST_TIMEOUT  = 3'd5,
    ST_BIST_ERR = 3'd6
  } sup_status_e;

  localparam int STATE_W  = 3;
  localparam int STATUS_W = 3;

endpackage

// File: rtl/riscv_region_checker.sv
// Combinational address-window checker.
//   addr     : data bus address under test
//   wr_legal : addr lies in a window that permits writes
//   rd_legal : addr lies in any window, or reads are not being checked
// Windows are inclusive on both ends.
module riscv_region_checker #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_BASE  = '0,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_LIMIT = '0,
  parameter logic [NUM_REGIONS-1:0]                 REGION_WR_EN = '0,
  parameter bit   CHECK_READS = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_legal,
  output logic                  rd_legal
);

  logic [NUM_REGIONS-1:0] hit;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    assign hit[i] = (addr >= REGION_BASE[i]) && (addr <= REGION_LIMIT[i]);
  end

  assign wr_legal = |(hit & REGION_WR_EN);
  // With read checking off every read counts as legal.
  assign rd_legal = !CHECK_READS || (|hit);

endmodule

// File: rtl/riscv_run_supervisor.sv
// Run controller between the LBIST engine and the RI5CY wrapper.
// Waits for BIST, holds core reset RESET_WAIT_CYCLES cycles, runs the core
// under a cycle watchdog while checking data accesses against address
// windows, and ends in a sticky encoded verdict.
//   Inputs : clk_i, rst_ni, bist_done_i/bist_pass_i, max_cycles_i,
//            data_req_i/gnt_i/we_i/addr_i, tests_passed_i/failed_i,
//            exit_valid_i/exit_value_i
//   Outputs: core_rst_no, fetch_enable_o, state_o, done_o, status_o,
//            cycle_cnt_o, viol_cnt_o, viol_valid_o, first_viol_addr_o
module riscv_run_supervisor
  import riscv_supervisor_pkg::*;
#(
  parameter int NUM_REGIONS       = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int CNT_WIDTH         = 32,
  parameter int RESET_WAIT_CYCLES = 4,
  parameter bit CHECK_READS       = 1'b0,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_BASE  = {32'h1000_0000, 32'h0020_0000},
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_LIMIT = {32'h1000_FFFF, 32'h0024_0000},
  parameter logic [NUM_REGIONS-1:0]                 REGION_WR_EN = 2'b11
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  bist_done_i,
  input  logic                  bist_pass_i,
  input  logic [CNT_WIDTH-1:0]  max_cycles_i,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  tests_passed_i,
  input  logic                  tests_failed_i,
  input  logic                  exit_valid_i,
  input  logic [31:0]           exit_value_i,
  output logic                  core_rst_no,
  output logic                  fetch_enable_o,
  output logic [STATE_W-1:0]    state_o,
  output logic                  done_o,
  output logic [STATUS_W-1:0]   status_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  viol_cnt_o,
  output logic                  viol_valid_o,
  output logic [ADDR_WIDTH-1:0] first_viol_addr_o
);

  localparam int HOLD_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_WAIT_CYCLES - 1);

  sup_state_e        state;
  sup_status_e       status;
  logic [HOLD_W-1:0] hold_cnt;
  logic              wr_legal, rd_legal;
  logic              illegal;
  logic              term;
  sup_status_e       term_status;

  riscv_region_checker #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REGION_BASE (REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT),
    .REGION_WR_EN(REGION_WR_EN),
    .CHECK_READS (CHECK_READS)
  ) u_checker (
    .addr    (data_addr_i),
    .wr_legal(wr_legal),
    .rd_legal(rd_legal)
  );

  // Qualification by RUN happens in the FSM; this is just "granted and bad".
  assign illegal = data_req_i && data_gnt_i && (data_we_i ? !wr_legal : !rd_legal);

  // Termination priority: fail > exit > pass > watchdog.
  always_comb begin
    term        = 1'b1;
    term_status = ST_NONE;
    if (tests_failed_i)      term_status = ST_FAIL;
    else if (exit_valid_i)   term_status = (exit_value_i == 32'd0) ? ST_EXIT_OK : ST_EXIT_ERR;
    else if (tests_passed_i) term_status = ST_PASS;
    else if ((max_cycles_i != '0) && (cycle_cnt_o >= max_cycles_i)) term_status = ST_TIMEOUT;
    else                     term = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= WAIT_BIST;
      status            <= ST_NONE;
      hold_cnt          <= '0;
      core_rst_no       <= 1'b0;
      fetch_enable_o    <= 1'b0;
      done_o            <= 1'b0;
      cycle_cnt_o       <= '0;
      viol_cnt_o        <= '0;
      viol_valid_o      <= 1'b0;
      first_viol_addr_o <= '0;
    end else begin
      case (state)
        WAIT_BIST: begin
          if (bist_done_i) begin
            if (bist_pass_i) begin
              state    <= RESET_HOLD;
              hold_cnt <= '0;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
              status <= ST_BIST_ERR;
            end
          end
        end
        RESET_HOLD: begin
          // Release lands on the same edge that enters RUN, so the core sees
          // reset for exactly RESET_WAIT_CYCLES cycles.
          if (hold_cnt == HOLD_LAST) begin
            state          <= RUN;
            core_rst_no    <= 1'b1;
            fetch_enable_o <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
          if (illegal) begin
            if (viol_cnt_o != '1) viol_cnt_o <= viol_cnt_o + CNT_WIDTH'(1);
            if (!viol_valid_o) begin
              viol_valid_o      <= 1'b1;
              first_viol_addr_o <= data_addr_i;
            end
          end
          if (term) begin
            state  <= DONE;
            done_o <= 1'b1;
            status <= term_status;
          end
        end
        default: ; // DONE absorbs until reset
      endcase
    end
  end

  assign state_o  = STATE_W'(state);
  assign status_o = status;

endmodule

// File: tb/tb_riscv_run_supervisor.sv
module tb_riscv_run_supervisor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        bist_done_i = 1'b0, bist_pass_i = 1'b0;
  logic [31:0] max_cycles_i = '0;
  logic        data_req_i = 1'b0, data_gnt_i = 1'b0, data_we_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        tests_passed_i = 1'b0, tests_failed_i = 1'b0, exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic        core_rst_no, fetch_enable_o, done_o, viol_valid_o;
  logic [2:0]  state_o, status_o;
  logic [31:0] cycle_cnt_o, viol_cnt_o, first_viol_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  riscv_run_supervisor dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bist_done_i(bist_done_i), .bist_pass_i(bist_pass_i),
    .max_cycles_i(max_cycles_i),
    .data_req_i(data_req_i), .data_gnt_i(data_gnt_i), .data_we_i(data_we_i),
    .data_addr_i(data_addr_i),
    .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .core_rst_no(core_rst_no), .fetch_enable_o(fetch_enable_o),
    .state_o(state_o), .done_o(done_o), .status_o(status_o),
    .cycle_cnt_o(cycle_cnt_o), .viol_cnt_o(viol_cnt_o),
    .viol_valid_o(viol_valid_o), .first_viol_addr_o(first_viol_addr_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  state_o, 3'd0);
    chk({tag, "_rstn"},   core_rst_no, 1'b0);
    chk({tag, "_fetch"},  fetch_enable_o, 1'b0);
    chk({tag, "_done"},   done_o, 1'b0);
    chk({tag, "_status"}, status_o, 3'd0);
    chk({tag, "_cyc"},    cycle_cnt_o, 32'd0);
    chk({tag, "_viol"},   viol_cnt_o, 32'd0);
    chk({tag, "_vvalid"}, viol_valid_o, 1'b0);
    chk({tag, "_vaddr"},  first_viol_addr_o, 32'd0);
  endtask

  task automatic clear_inputs();
    data_req_i = 1'b0; data_gnt_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
    tests_passed_i = 1'b0; tests_failed_i = 1'b0; exit_valid_i = 1'b0; exit_value_i = '0;
  endtask

  // Reset, pass BIST and return on the first negedge in RUN.
  task automatic start_run();
    bit reached;
    @(negedge clk_i);
    rst_ni = 1'b0; bist_done_i = 1'b0; bist_pass_i = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1; bist_done_i = 1'b1; bist_pass_i = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk_i);
      if (state_o == 3'd2) reached = 1'b1;
    end
    chk("reach_run", reached, 1'b1);
  endtask

  typedef struct {
    logic req, gnt, we;
    logic [31:0] addr;
    logic [31:0] exp_viol;
    logic [31:0] exp_first;
  } acc_vec_t;

  typedef struct {
    logic        f, ev;
    logic [31:0] val;
    logic        p;
    logic [2:0]  exp_status;
  } term_vec_t;

  acc_vec_t  av[9];
  term_vec_t tv[5];

  initial begin
    int cnt;
    bit seen;

    av[0] = '{1'b1, 1'b1, 1'b1, 32'h0010_0000, 32'd1, 32'h0010_0000};
    av[1] = '{1'b1, 1'b1, 1'b1, 32'h0030_0000, 32'd2, 32'h0010_0000};
    av[2] = '{1'b1, 1'b1, 1'b1, 32'h0020_0000, 32'd2, 32'h0010_0000};
    av[3] = '{1'b1, 1'b1, 1'b1, 32'h0024_0000, 32'd2, 32'h0010_0000};
    av[4] = '{1'b1, 1'b0, 1'b1, 32'h0030_0000, 32'd2, 32'h0010_0000}; // not granted
    av[5] = '{1'b1, 1'b1, 1'b0, 32'h0030_0000, 32'd2, 32'h0010_0000}; // read, unchecked
    av[6] = '{1'b1, 1'b1, 1'b1, 32'h1000_FFFF, 32'd2, 32'h0010_0000};
    av[7] = '{1'b1, 1'b1, 1'b1, 32'h1001_0000, 32'd3, 32'h0010_0000};
    av[8] = '{1'b1, 1'b1, 1'b1, 32'h001F_FFFF, 32'd4, 32'h0010_0000};

    tv[0] = '{1'b1, 1'b1, 32'd0, 1'b1, 3'd2};
    tv[1] = '{1'b0, 1'b1, 32'd0, 1'b1, 3'd3};
    tv[2] = '{1'b0, 1'b1, 32'd7, 1'b0, 3'd4};
    tv[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 3'd1};
    tv[4] = '{1'b0, 1'b1, 32'd7, 1'b1, 3'd4};

    // ---- reset state and BIST hold timing ----
    @(negedge clk_i);
    chk_reset_vals("rst");
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("wait_bist_state", state_o, 3'd0);
    end
    bist_done_i = 1'b1; bist_pass_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("hold_state", state_o, 3'd1);
      chk("hold_rstn", core_rst_no, 1'b0);
    end
    @(negedge clk_i);
    chk("run_state", state_o, 3'd2);
    chk("run_rstn", core_rst_no, 1'b1);
    chk("run_fetch", fetch_enable_o, 1'b1);
    chk("run_cyc0", cycle_cnt_o, 32'd0);

    // ---- access monitor table ----
    for (int i = 0; i < 9; i++) begin
      data_req_i = av[i].req; data_gnt_i = av[i].gnt;
      data_we_i = av[i].we; data_addr_i = av[i].addr;
      @(negedge clk_i);
      chk($sformatf("viol_cnt[%0d]", i), viol_cnt_o, av[i].exp_viol);
      chk($sformatf("viol_first[%0d]", i), first_viol_addr_o, av[i].exp_first);
      chk($sformatf("viol_valid[%0d]", i), viol_valid_o, 1'b1 & (av[i].exp_viol != 0));
      chk($sformatf("cyc[%0d]", i), cycle_cnt_o, 32'(i + 1));
    end
    clear_inputs();
    tests_passed_i = 1'b1;
    @(negedge clk_i);
    chk("pass_done", done_o, 1'b1);
    chk("pass_status", status_o, 3'd1);
    chk("pass_state", state_o, 3'd3);
    // DONE must ignore later flags and accesses; counters freeze (terminating cycle counted)
    tests_passed_i = 1'b0; tests_failed_i = 1'b1;
    data_req_i = 1'b1; data_gnt_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0030_0000;
    repeat (3) @(negedge clk_i);
    chk("done_status_sticky", status_o, 3'd1);
    chk("done_viol_frozen", viol_cnt_o, 32'd4);
    chk("done_cyc_frozen", cycle_cnt_o, 32'd10);
    chk("done_rstn", core_rst_no, 1'b1);
    chk("done_fetch", fetch_enable_o, 1'b1);
    clear_inputs();

    // ---- BIST failure ----
    rst_ni = 1'b0; bist_done_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1; bist_done_i = 1'b1; bist_pass_i = 1'b0;
    @(negedge clk_i);
    chk("bist_err_status", status_o, 3'd6);
    chk("bist_err_done", done_o, 1'b1);
    bist_pass_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("bist_err_rstn", core_rst_no, 1'b0);
    chk("bist_err_fetch", fetch_enable_o, 1'b0);
    chk("bist_err_state", state_o, 3'd3);

    // ---- watchdog ----
    max_cycles_i = 32'd100;
    start_run();
    seen = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_i);
      cnt++;
      if (done_o) seen = 1'b1;
    end
    chk("wd_fired", seen, 1'b1);
    chk("wd_status", status_o, 3'd5);
    // terminating cycle is the 101st RUN cycle (count read 100 there)
    chk("wd_latency", cnt, 101);
    chk("wd_cyc", cycle_cnt_o, 32'd101);

    max_cycles_i = 32'd0;
    start_run();
    repeat (300) @(negedge clk_i);
    chk("wd_off_done", done_o, 1'b0);
    chk("wd_off_cyc", cycle_cnt_o, 32'd300);

    // ---- termination priority table ----
    for (int i = 0; i < 5; i++) begin
      start_run();
      tests_failed_i = tv[i].f; exit_valid_i = tv[i].ev;
      exit_value_i = tv[i].val; tests_passed_i = tv[i].p;
      @(negedge clk_i);
      clear_inputs();
      chk($sformatf("term_done[%0d]", i), done_o, 1'b1);
      chk($sformatf("term_status[%0d]", i), status_o, tv[i].exp_status);
    end

    // ---- asynchronous reset mid-RUN ----
    start_run();
    data_req_i = 1'b1; data_gnt_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0030_0000;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_viol", viol_cnt_o, 32'd3);
    clear_inputs();
    bist_done_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 chk("async_rstn", core_rst_no, 1'b0);
    chk_reset_vals("midrun");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("restart_wait", state_o, 3'd0);
    bist_done_i = 1'b1; bist_pass_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("restart_run", state_o, 3'd2);
    chk("restart_rstn", core_rst_no, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
